// File: rtl/gray_sync_decoder.sv
// Gray-code input synchronizer and step checker.
// Samples an asynchronous Gray bus through a flop chain, decodes it to binary,
// classifies each change as +1, -1 or illegal, and drops into a sticky fault
// after ERR_LIMIT illegal jumps in a row.
module gray_sync_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_LIMIT   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clear_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             delta_err,
    output logic [7:0]       err_count,
    output logic             fault
);

    localparam int CW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DELTA_UP = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DELTA_DN = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] s_bin, delta;

    state_t           state_q, state_n;
    logic [CW-1:0]    wait_q, wait_n;
    logic [WIDTH-1:0] p_q, p_n;
    logic [WIDTH-1:0] bin_q, bin_n;
    logic             up_q, up_n, dn_q, dn_n, err_q, err_n;
    logic [7:0]       cnt_q, cnt_n;
    logic [3:0]       consec_q, consec_n;

    // Synchronizer chain; only the last stage is ever observed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};
    end

    assign s_bin = gray2bin(sync_q[SYNC_STAGES-1]);
    assign delta = s_bin - p_q;   // wraps mod 2^WIDTH

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT;
            wait_q   <= '0;
            p_q      <= '0;
            bin_q    <= '0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            consec_q <= '0;
        end else begin
            state_q  <= state_n;
            wait_q   <= wait_n;
            p_q      <= p_n;
            bin_q    <= bin_n;
            up_q     <= up_n;
            dn_q     <= dn_n;
            err_q    <= err_n;
            cnt_q    <= cnt_n;
            consec_q <= consec_n;
        end
    end

    // Next-state and step classification; clear_err overrides everything.
    always_comb begin
        state_n  = state_q;
        wait_n   = wait_q;
        p_n      = p_q;
        bin_n    = bin_q;
        up_n     = 1'b0;
        dn_n     = 1'b0;
        err_n    = 1'b0;
        cnt_n    = cnt_q;
        consec_n = consec_q;

        if (clear_err) begin
            state_n  = S_INIT;
            wait_n   = '0;
            cnt_n    = '0;
            consec_n = '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    // Let the chain refill before trusting its output.
                    if (wait_q == CW'(SYNC_STAGES)) begin
                        bin_n   = s_bin;
                        p_n     = s_bin;
                        wait_n  = '0;
                        state_n = S_TRACK;
                    end else begin
                        wait_n = wait_q + 1'b1;
                    end
                end
                S_TRACK: begin
                    p_n = s_bin;
                    if (delta == DELTA_UP) begin
                        bin_n    = s_bin;
                        up_n     = 1'b1;
                        consec_n = '0;
                    end else if (delta == DELTA_DN) begin
                        bin_n    = s_bin;
                        dn_n     = 1'b1;
                        consec_n = '0;
                    end else if (delta != '0) begin
                        // Illegal jump: still follow the input so we resync.
                        bin_n    = s_bin;
                        err_n    = 1'b1;
                        consec_n = consec_q + 1'b1;
                        if (cnt_q != 8'hFF) cnt_n = cnt_q + 1'b1;
                        if (consec_n == 4'(ERR_LIMIT)) state_n = S_FAULT;
                    end
                end
                S_FAULT: begin
                    // Sticky: only clear_err or rst leave this state.
                end
                default: state_n = S_INIT;
            endcase
        end
    end

    assign bin_out   = bin_q;
    assign bin_valid = (state_q == S_TRACK);
    assign fault     = (state_q == S_FAULT);
    assign step_up   = up_q;
    assign step_dn   = dn_q;
    assign delta_err = err_q;
    assign err_count = cnt_q;

endmodule
